// File: rtl/lru_req_queue.sv
// lru_req_queue: per-requester FIFOs feeding an LRU arbiter, registered valid/ready output.
// Optional grant checking with sticky error flags under `LRU_REQ_QUEUE_ERR_EN.
module lru_req_queue #(
  parameter int NUM_REQ = 10,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic [NUM_REQ-1:0]              in_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  in_data,
  output logic [NUM_REQ-1:0]              in_ready,
  output logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              gnt,
  output logic                            out_valid,
  output logic [DATA_W-1:0]               out_data,
  output logic [IW-1:0]                   out_port,
  input  logic                            out_ready,
  output logic                            err_spurious,
  output logic                            err_multi
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic                           slot_free, do_pop;
  logic [NUM_REQ-1:0]             qgnt, push, pop;
  logic [NUM_REQ-1:0][DATA_W-1:0] head;
  logic [IW-1:0]                  idx;
  logic                           out_valid_q, out_valid_d;
  logic [DATA_W-1:0]              out_data_q, out_data_d;
  logic [IW-1:0]                  out_port_q, out_port_d;
  assign slot_free = ~out_valid_q | out_ready;
  assign qgnt      = gnt & req;
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (qgnt[i]) idx = IW'(i);
  end
`ifdef LRU_REQ_QUEUE_ERR_EN
  logic multi, err_spurious_q, err_multi_q;
  assign multi  = |(qgnt & (qgnt - NUM_REQ'(1)));
  assign do_pop = |qgnt & ~multi;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      err_spurious_q <= 1'b0;
      err_multi_q    <= 1'b0;
    end else begin
      err_spurious_q <= err_spurious_q | |(gnt & ~req);
      err_multi_q    <= err_multi_q | multi;
    end
  assign err_spurious = err_spurious_q;
  assign err_multi    = err_multi_q;
`else
  assign do_pop       = |qgnt;
  assign err_spurious = 1'b0;
  assign err_multi    = 1'b0;
`endif
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     cnt_q;
    assign in_ready[g] = cnt_q != CW'(DEPTH);
    assign req[g]      = (cnt_q != '0) & slot_free;
    assign push[g]     = in_valid[g] & in_ready[g];
    assign pop[g]      = do_pop & (idx == IW'(g));
    assign head[g]     = mem_q[rd_q];
    always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push[g]) wr_q <= wr_q + PW'(1);
        if (pop[g]) rd_q <= rd_q + PW'(1);
        cnt_q <= cnt_q + CW'(push[g]) - CW'(pop[g]);
      end
    always_ff @(posedge clk)
      if (push[g]) mem_q[wr_q] <= in_data[g];
  end
  always_comb begin
    out_valid_d = do_pop | (out_valid_q & ~out_ready);
    out_data_d  = do_pop ? head[idx] : out_data_q;
    out_port_d  = do_pop ? idx : out_port_q;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
    end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;
endmodule
